// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : wb_pkg
//  Purpose : Shared types and constants for the writeback unit.
//            XLEN / REG_AW give the default result width and register index
//            width; wb_req_t bundles one producer result; wb_src_e names the
//            two producers (ALU = 0, LSU = 1).
//  Rev     : 1.0  initial release
// ============================================================================
package wb_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic [REG_AW-1:0] dest;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } wb_src_e;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/wb_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module  : wb_rr_arb2
//  Purpose : Two-request arbiter producing a one-hot grant in the same cycle.
//            Round-robin mode: on a conflict the source named by the pointer
//            wins and the pointer then moves to the loser. Fixed-priority
//            mode: request 1 (LSU) always wins a conflict.
//  Ports   : clk     in   clock
//            rst     in   asynchronous active-high reset; forces gnt_o to 0
//            req_i   in   [1:0] requests, bit 0 = ALU, bit 1 = LSU
//            gnt_o   out  [1:0] one-hot grant
//  Rev     : 1.0  initial release
// ============================================================================
module wb_rr_arb2
  import wb_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  wb_src_e ptr_q;
  wb_src_e ptr_d;

  always_comb begin
    gnt_o = 2'b00;
    ptr_d = ptr_q;
    if (!rst) begin
      unique case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11: begin
          if (FIXED_PRIO) begin
            gnt_o = 2'b10;
          end else begin
            gnt_o = (ptr_q == SRC_ALU) ? 2'b01 : 2'b10;
            // Every grant is a transfer, so the loser gets the next conflict.
            ptr_d = (ptr_q == SRC_ALU) ? SRC_LSU : SRC_ALU;
          end
        end
        default: gnt_o = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= SRC_ALU;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule : wb_rr_arb2
`default_nettype wire

// File: rtl/wb_writeback_unit.sv
`default_nettype none
// ============================================================================
//  Module  : wb_writeback_unit
//  Purpose : Writeback stage. Arbitrates ALU and LSU results, issues one
//            registered register-file write per cycle and tracks which
//            registers have a write in flight (busy scoreboard).
//  Ports   : clk, rst              clock / async active-high reset
//            alu_valid_i/ready_o   ALU handshake, alu_dest_i, alu_data_i
//            lsu_valid_i/ready_o   LSU handshake, lsu_dest_i, lsu_data_i
//            issue_en_i/dest_i     decode marks issue_dest_i as pending
//            wr_en_o/dest_o/data_o registered regfile write port
//            busy_o                pending-write vector, bit 0 always 0
//  Rev     : 1.0  initial release
// ============================================================================
module wb_writeback_unit #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter bit LSU_PRIO = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid_i,
  output logic                     alu_ready_o,
  input  logic [$clog2(NREGS)-1:0] alu_dest_i,
  input  logic [XLEN-1:0]          alu_data_i,
  input  logic                     lsu_valid_i,
  output logic                     lsu_ready_o,
  input  logic [$clog2(NREGS)-1:0] lsu_dest_i,
  input  logic [XLEN-1:0]          lsu_data_i,
  input  logic                     issue_en_i,
  input  logic [$clog2(NREGS)-1:0] issue_dest_i,
  output logic                     wr_en_o,
  output logic [$clog2(NREGS)-1:0] wr_dest_o,
  output logic [XLEN-1:0]          wr_data_o,
  output logic [NREGS-1:0]         busy_o
);

  import wb_pkg::*;

  localparam int AW = $clog2(NREGS);

  logic [1:0]      gnt;
  logic            xfer;
  wb_src_e         sel_src;
  logic [AW-1:0]   sel_dest;
  logic [XLEN-1:0] sel_data;

  logic            wr_en_q,   wr_en_d;
  logic [AW-1:0]   wr_dest_q;
  logic [XLEN-1:0] wr_data_q;
  logic [NREGS-1:0] busy_q, busy_d;
  logic [NREGS-1:0] set_vec, clr_vec;

  // --------------------------------------------------------------------------
  // Arbitration: a grant is always a transfer since nothing else stalls.
  // --------------------------------------------------------------------------
  wb_rr_arb2 #(
    .FIXED_PRIO (LSU_PRIO)
  ) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i ({lsu_valid_i, alu_valid_i}),
    .gnt_o (gnt)
  );

  assign alu_ready_o = gnt[0];
  assign lsu_ready_o = gnt[1];
  assign xfer        = |gnt;

  // --------------------------------------------------------------------------
  // Result mux
  // --------------------------------------------------------------------------
  always_comb begin
    sel_src  = gnt[1] ? SRC_LSU : SRC_ALU;
    sel_dest = (sel_src == SRC_LSU) ? lsu_dest_i : alu_dest_i;
    sel_data = (sel_src == SRC_LSU) ? lsu_data_i : alu_data_i;
    // x0 results are consumed but never written.
    wr_en_d  = xfer && (sel_dest != '0);
  end

  // --------------------------------------------------------------------------
  // Output register stage: dest/data keep their last values when idle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_dest_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= wr_en_d;
      if (xfer) begin
        wr_dest_q <= sel_dest;
        wr_data_q <= sel_data;
      end
    end
  end

  assign wr_en_o   = wr_en_q;
  assign wr_dest_o = wr_dest_q;
  assign wr_data_o = wr_data_q;

  // --------------------------------------------------------------------------
  // Scoreboard. Bit 0 is never decoded, so x0 can neither set nor clear.
  // A same-cycle set overrides a clear: the issued instruction is newer.
  // --------------------------------------------------------------------------
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    for (int i = 1; i < NREGS; i++) begin
      set_vec[i] = issue_en_i && (issue_dest_i == AW'(i));
      clr_vec[i] = xfer && (sel_dest == AW'(i));
    end
    busy_d    = (busy_q & ~clr_vec) | set_vec;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

endmodule : wb_writeback_unit
`default_nettype wire
